// File: rtl/demux1a4_ochobits_pkg.sv
// Shared TDM definitions for the 4:1 byte link: slot width, lane count and the
// fixed slot order, so transmitter and receiver agree on one encoding.
package demux1a4_ochobits_pkg;

  localparam int SLOT_W    = 2;
  localparam int NUM_LANES = 4;

  localparam logic [SLOT_W-1:0] SLOT0 = 2'd0;
  localparam logic [SLOT_W-1:0] SLOT1 = 2'd1;
  localparam logic [SLOT_W-1:0] SLOT2 = 2'd2;
  localparam logic [SLOT_W-1:0] SLOT3 = 2'd3;

  // Free-running slot order; the last slot wraps back to the first.
  function automatic logic [SLOT_W-1:0] next_slot(input logic [SLOT_W-1:0] cur);
    logic [SLOT_W-1:0] nxt;
    if (cur == SLOT3) begin
      nxt = SLOT0;
    end else begin
      nxt = cur + {{(SLOT_W-1){1'b0}}, 1'b1};
    end
    return nxt;
  endfunction

endpackage

// File: rtl/demux_slot_counter.sv
// Free-running TDM slot counter for the receive side; flags the last slot of a group.
module demux_slot_counter
  import demux1a4_ochobits_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  output logic [SLOT_W-1:0] slot,
  output logic              last_slot
);

  logic [SLOT_W-1:0] slot_q;
  logic [SLOT_W-1:0] slot_d;

  // Advance one slot per edge regardless of data validity.
  always_comb begin
    slot_d = next_slot(slot_q);
  end

  // Slot register; reset realigns to slot 0 with the transmitter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q <= SLOT0;
    end else begin
      slot_q <= slot_d;
    end
  end

  assign slot      = slot_q;
  assign last_slot = (slot_q == SLOT3);

endmodule

// File: rtl/demux1a4_ochobits.sv
// 1:4 byte demultiplexer: rebuilds four parallel lanes from a TDM byte stream,
// presenting all lanes together on the slot-3 edge with a one-cycle group strobe.
module demux1a4_ochobits
  import demux1a4_ochobits_pkg::*;
#(
  parameter int                DATA_W    = 8,
  parameter logic [DATA_W-1:0] IDLE_FILL = {DATA_W{1'b0}}
)
(
  input  logic              clk_4f,
  input  logic              reset_L,
  input  logic              valid_in,
  input  logic [DATA_W-1:0] data_in,
  output logic              valid0,
  output logic              valid1,
  output logic              valid2,
  output logic              valid3,
  output logic [DATA_W-1:0] data_out0,
  output logic [DATA_W-1:0] data_out1,
  output logic [DATA_W-1:0] data_out2,
  output logic [DATA_W-1:0] data_out3,
  output logic              group_stb,
  output logic [SLOT_W-1:0] slot
);

  logic [SLOT_W-1:0]    slot_s;
  logic                 last_slot_s;
  logic [DATA_W-1:0]    slot_byte_s;

  logic [NUM_LANES-2:0] stage_v_q;
  logic [NUM_LANES-2:0] stage_v_d;
  logic [DATA_W-1:0]    stage_d_q [0:NUM_LANES-2];
  logic [DATA_W-1:0]    stage_d_d [0:NUM_LANES-2];

  logic [NUM_LANES-1:0] lane_v_q;
  logic [NUM_LANES-1:0] lane_v_d;
  logic [DATA_W-1:0]    lane_d_q [0:NUM_LANES-1];
  logic [DATA_W-1:0]    lane_d_d [0:NUM_LANES-1];

  logic                 group_stb_q;
  logic                 group_stb_d;

  demux_slot_counter u_slot_counter (
    .clk       (clk_4f),
    .rst_n     (reset_L),
    .slot      (slot_s),
    .last_slot (last_slot_s)
  );

  // Stage slots 0..2; on slot 3 present the whole group at once so no lane updates early.
  always_comb begin
    stage_v_d   = stage_v_q;
    stage_d_d   = stage_d_q;
    lane_v_d    = lane_v_q;
    lane_d_d    = lane_d_q;
    group_stb_d = 1'b0;
    // Gating here keeps an undefined data_in on an idle slot away from every register.
    if (valid_in) begin
      slot_byte_s = data_in;
    end else begin
      slot_byte_s = IDLE_FILL;
    end
    if (last_slot_s) begin
      for (int k = 0; k < NUM_LANES - 1; k++) begin
        lane_v_d[k] = stage_v_q[k];
        lane_d_d[k] = stage_d_q[k];
      end
      lane_v_d[NUM_LANES-1] = valid_in;
      lane_d_d[NUM_LANES-1] = slot_byte_s;
      group_stb_d           = 1'b1;
    end else begin
      stage_v_d[slot_s] = valid_in;
      stage_d_d[slot_s] = slot_byte_s;
    end
  end

  // Staging and output registers; async reset drops any partial group.
  always_ff @(posedge clk_4f or negedge reset_L) begin
    if (!reset_L) begin
      stage_v_q   <= {(NUM_LANES-1){1'b0}};
      lane_v_q    <= {NUM_LANES{1'b0}};
      group_stb_q <= 1'b0;
      for (int k = 0; k < NUM_LANES - 1; k++) begin
        stage_d_q[k] <= IDLE_FILL;
      end
      for (int k = 0; k < NUM_LANES; k++) begin
        lane_d_q[k] <= IDLE_FILL;
      end
    end else begin
      stage_v_q   <= stage_v_d;
      stage_d_q   <= stage_d_d;
      lane_v_q    <= lane_v_d;
      lane_d_q    <= lane_d_d;
      group_stb_q <= group_stb_d;
    end
  end

  assign valid0    = lane_v_q[0];
  assign valid1    = lane_v_q[1];
  assign valid2    = lane_v_q[2];
  assign valid3    = lane_v_q[3];
  assign data_out0 = lane_d_q[0];
  assign data_out1 = lane_d_q[1];
  assign data_out2 = lane_d_q[2];
  assign data_out3 = lane_d_q[3];
  assign group_stb = group_stb_q;
  assign slot      = slot_s;

endmodule

// File: tb/tb_demux1a4_ochobits.sv
// Self-checking bench for demux1a4_ochobits: directed groups, async reset mid-group,
// and a long random stream against a slot-indexed reference model.
module tb_demux1a4_ochobits;

  logic       clk_4f = 1'b0;
  logic       reset_L;
  logic       valid_in;
  logic [7:0] data_in;
  logic       valid0, valid1, valid2, valid3;
  logic [7:0] data_out0, data_out1, data_out2, data_out3;
  logic       group_stb;
  logic [1:0] slot;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state: edges since release, bytes seen per slot, expected outputs
  int         n_edges;
  logic [7:0] win_d [4];
  logic       win_v [4];
  logic [7:0] exp_d [4];
  logic       exp_v [4];
  logic       exp_stb;

  logic [7:0] obs_d [4];
  logic       obs_v [4];

  demux1a4_ochobits dut (
    .clk_4f    (clk_4f),
    .reset_L   (reset_L),
    .valid_in  (valid_in),
    .data_in   (data_in),
    .valid0    (valid0),
    .valid1    (valid1),
    .valid2    (valid2),
    .valid3    (valid3),
    .data_out0 (data_out0),
    .data_out1 (data_out1),
    .data_out2 (data_out2),
    .data_out3 (data_out3),
    .group_stb (group_stb),
    .slot      (slot)
  );

  always #5 clk_4f = ~clk_4f;

  assign obs_d[0] = data_out0;
  assign obs_d[1] = data_out1;
  assign obs_d[2] = data_out2;
  assign obs_d[3] = data_out3;
  assign obs_v[0] = valid0;
  assign obs_v[1] = valid1;
  assign obs_v[2] = valid2;
  assign obs_v[3] = valid3;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, expv, $time);
    end
  endtask

  task automatic model_reset();
    n_edges = 0;
    exp_stb = 1'b0;
    for (int k = 0; k < 4; k++) begin
      win_d[k] = 8'h00;
      win_v[k] = 1'b0;
      exp_d[k] = 8'h00;
      exp_v[k] = 1'b0;
    end
  endtask

  task automatic check_outputs(input string ctx);
    chk($sformatf("%s slot", ctx), 32'(slot), 32'(n_edges % 4));
    chk($sformatf("%s group_stb", ctx), 32'(group_stb), 32'(exp_stb));
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("%s valid%0d", ctx, k), 32'(obs_v[k]), 32'(exp_v[k]));
      chk($sformatf("%s data_out%0d", ctx, k), 32'(obs_d[k]), 32'(exp_d[k]));
    end
  endtask

  // Drive one slot, take one edge, advance the model, and check everything.
  task automatic drive_slot(input string ctx, input logic v, input logic [7:0] d);
    int k;
    valid_in = v;
    data_in  = d;
    @(posedge clk_4f);
    #1;
    n_edges++;
    k = (n_edges - 1) % 4;
    win_v[k] = v;
    win_d[k] = v ? d : 8'h00;
    if (k == 3) begin
      for (int j = 0; j < 4; j++) begin
        exp_v[j] = win_v[j];
        exp_d[j] = win_d[j];
      end
      exp_stb = 1'b1;
    end else begin
      exp_stb = 1'b0;
    end
    check_outputs(ctx);
  endtask

  initial begin
    reset_L  = 1'b0;
    valid_in = 1'b0;
    data_in  = 8'h00;
    model_reset();
    #12;
    check_outputs("reset");
    @(negedge clk_4f);
    reset_L = 1'b1;

    // 1: single valid group A0..A3
    for (int i = 0; i < 4; i++) drive_slot("grpA", 1'b1, 8'hA0 + 8'(i));

    // 2: continuous stream 00..0F, outputs must hold between strobes
    for (int i = 0; i < 16; i++) drive_slot("stream", 1'b1, 8'(i));

    // 3: slot 1 idle with garbage on data_in
    drive_slot("idle1", 1'b1, 8'h51);
    drive_slot("idle1", 1'b0, 8'hFF);
    drive_slot("idle1", 1'b1, 8'h53);
    drive_slot("idle1", 1'b1, 8'h54);

    // 4: whole group idle
    for (int i = 0; i < 4; i++) drive_slot("allidle", 1'b0, 8'hFF);

    // 5: reset asserted after slot 2 of a group following a valid group
    for (int i = 0; i < 4; i++) drive_slot("prerst", 1'b1, 8'hC0 + 8'(i));
    for (int i = 0; i < 3; i++) drive_slot("partial", 1'b1, 8'hD0 + 8'(i));
    #2;
    reset_L = 1'b0;
    #1;
    model_reset();
    check_outputs("async_rst");
    @(posedge clk_4f);
    #1;
    check_outputs("rst_held");
    @(negedge clk_4f);
    reset_L = 1'b1;
    for (int i = 0; i < 4; i++) drive_slot("postrst", 1'b1, 8'hB0 + 8'(i));

    // 6: long random stream, random valids and bytes per slot
    for (int g = 0; g < 1000; g++) begin
      for (int i = 0; i < 4; i++) begin
        drive_slot("rand", 1'($urandom_range(0, 1)), 8'($urandom));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
